// File: rtl/opb_register_simulink2ppc_fifo_if.sv
// OPB slave-side bus bundle for the fabric-to-PowerPC FIFO register block.
// Bit 0 is the MSB on every bus (IBM ordering), so numeric assignment maps OPB bit i to fabric bit 31-i.
interface opb_register_simulink2ppc_fifo_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    // Handshake: a transfer is offered while OPB_select=1 and completes in the single cycle Sl_xferAck=1.
    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_fifo.sv
// Fabric-to-PowerPC FIFO exposed as OPB registers: DATA (pop), STATUS, CONTROL (clear/flush).
// Read data and side effects are captured on the hit edge; the pop/control action commits in the ack cycle.
module opb_register_simulink2ppc_fifo #(
    parameter logic [31:0] C_BASEADDR   = 32'h01080B00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01080BFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter int          C_DEPTH_LOG2 = 4
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst,
    opb_register_simulink2ppc_fifo_if.slave   opb,
    input  logic [31:0]                       user_data_in,
    input  logic                              user_we,
    output logic                              user_full
);
    localparam int AW    = C_DEPTH_LOG2;
    localparam int CW    = C_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << C_DEPTH_LOG2;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          ovf, unf;
    logic          ack;
    logic [31:0]   dbus_q;
    logic          pop_q;
    logic [2:0]    ctl_q;

    logic          hit, ack_next, empty, push_ok, ovf_set, flush;
    logic [1:0]    offset;
    logic [31:0]   wdata, rdata, status;

    assign hit      = opb.OPB_select && (opb.OPB_ABus >= C_BASEADDR) && (opb.OPB_ABus <= C_HIGHADDR);
    assign ack_next = hit && !ack;
    assign offset   = opb.OPB_ABus[28:29];
    assign wdata    = opb.OPB_DBus;
    assign empty    = (count == '0);
    assign flush    = ctl_q[2];

    // A full FIFO still accepts a word when the ack cycle of a DATA read frees a slot.
    assign push_ok    = user_we && (!user_full || pop_q) && !flush;
    assign ovf_set    = user_we && user_full && !pop_q && !flush;
    assign count_next = count + CW'(push_ok) - CW'(pop_q);

    assign status = {14'd0, unf, ovf, 2'd0, user_full, empty, 3'd0, 9'(count)};

    always_comb begin
        rdata = '0;
        if (opb.OPB_RNW) begin
            case (offset)
                2'd0:    rdata = empty ? '0 : mem[rd_ptr];
                2'd1:    rdata = status;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            ack       <= 1'b0;
            dbus_q    <= '0;
            pop_q     <= 1'b0;
            ctl_q     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            user_full <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            ack    <= ack_next;
            dbus_q <= ack_next ? rdata : '0;
            pop_q  <= ack_next && opb.OPB_RNW && (offset == 2'd0) && !empty;
            ctl_q  <= (ack_next && !opb.OPB_RNW && (offset == 2'd2) && opb.OPB_BE[3]) ? wdata[2:0] : 3'd0;

            if (ack_next && opb.OPB_RNW && (offset == 2'd0) && empty) unf <= 1'b1;
            else if (ctl_q[1])                                        unf <= 1'b0;

            if (ovf_set)       ovf <= 1'b1;
            else if (ctl_q[0]) ovf <= 1'b0;

            if (flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                user_full <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_q)   rd_ptr <= rd_ptr + AW'(1);
                count     <= count_next;
                user_full <= (count_next == CW'(DEPTH));
            end
        end
    end

    // Storage has no reset so it maps onto RAM; contents are meaningless once the pointers clear.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst && push_ok) mem[wr_ptr] <= user_data_in;
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], wdata[31:3],
                         (C_OPB_AWIDTH != 32), (C_OPB_DWIDTH != 32), (C_FAMILY == "")};
endmodule

// File: tb/tb_opb_register_simulink2ppc_fifo.sv
// Bench for the OPB FIFO register block: a queue-based reference model predicts every read,
// and a negedge monitor pops the expected-response queue on each Sl_xferAck.
module tb_opb_register_simulink2ppc_fifo;
  localparam logic [31:0] BASE = 32'h01080B00;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] user_data_in = '0;
  logic        user_we = 1'b0;
  logic        user_full;

  opb_register_simulink2ppc_fifo_if bus();

  opb_register_simulink2ppc_fifo dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst_n),
    .opb          (bus.slave),
    .user_data_in (user_data_in),
    .user_we      (user_we),
    .user_full    (user_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  bit          exp_rd_q[$];
  logic [31:0] model_q[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(model_q.size());
    s[12] = (model_q.size() == 0);
    s[13] = (model_q.size() == DEPTH);
    s[16] = m_ovf;
    s[17] = m_unf;
    return s;
  endfunction

  function automatic logic [31:0] model_read(int off);
    if (off == 0) begin
      if (model_q.size() == 0) begin
        m_unf = 1;
        return 32'h0;
      end
      return model_q.pop_front();
    end
    if (off == 1) return model_status();
    return 32'h0;
  endfunction

  // Returns 1 when the write flushed the FIFO.
  function automatic bit model_write(int off, logic [3:0] be, logic [31:0] d);
    if (off == 2 && be[0]) begin
      if (d[0]) m_ovf = 0;
      if (d[1]) m_unf = 0;
      if (d[2]) begin
        model_q.delete();
        return 1;
      end
    end
    return 0;
  endfunction

  function automatic void model_push(logic [31:0] d);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    else m_ovf = 1;
  endfunction

  // Monitor: every ack consumes one expected entry; the bus must read 0 outside ack cycles.
  always @(negedge clk) begin
    if (bus.Sl_xferAck) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got 1 expected 0");
      end else begin
        logic [31:0] e;
        bit r;
        e = exp_q.pop_front();
        r = exp_rd_q.pop_front();
        if (r) check("read_data", bus.Sl_DBus, e);
      end
    end else if (rst_n) begin
      check("dbus_idle", bus.Sl_DBus, 32'h0);
    end
  end

  task automatic push_word(input logic [31:0] d);
    @(posedge clk); #1;
    user_we = 1'b1;
    user_data_in = d;
    @(posedge clk); #1;
    user_we = 1'b0;
    model_push(d);
    check("user_full", 32'(user_full), 32'(model_q.size() == DEPTH));
  endtask

  task automatic opb_xfer(input int off, input bit rnw, input logic [31:0] d, input logic [3:0] be,
                          input bit push_in_ack, input logic [31:0] pd);
    int waited;
    bit flushed;
    flushed = 0;
    if (rnw) begin
      exp_q.push_back(model_read(off));
      exp_rd_q.push_back(1);
    end else begin
      flushed = model_write(off, be, d);
      exp_q.push_back(32'h0);
      exp_rd_q.push_back(0);
    end
    if (push_in_ack && !flushed) model_push(pd);
    @(posedge clk); #1;
    bus.OPB_ABus = BASE + 32'(off * 4);
    bus.OPB_RNW = rnw;
    bus.OPB_DBus = d;
    bus.OPB_BE = be;
    bus.OPB_select = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!bus.Sl_xferAck && waited < 8);
    check("ack_latency", 32'(waited), 32'd1);
    bus.OPB_select = 1'b0;
    if (push_in_ack) begin
      user_we = 1'b1;
      user_data_in = pd;
      @(posedge clk); #1;
      user_we = 1'b0;
    end
  endtask

  task automatic rd(input int off);
    opb_xfer(off, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    opb_xfer(off, 1'b0, d, 4'hF, 1'b0, 32'h0);
  endtask

  initial begin
    bus.OPB_ABus = '0;
    bus.OPB_BE = '0;
    bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0;
    bus.OPB_select = 1'b0;
    bus.OPB_seqAddr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.Sl_xferAck), 32'h0);
    check("rst_dbus", bus.Sl_DBus, 32'h0);
    check("rst_full", 32'(user_full), 32'h0);
    rst_n = 1'b1;
    rd(1);

    // In-order readback of three words, then an empty status.
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    rd(0); rd(0); rd(0);
    rd(1);

    // Fill past full: the 17th word is dropped and flags overflow.
    for (int i = 0; i < 17; i++) push_word($urandom);
    rd(1);
    wr(2, 32'h1);
    rd(1);

    // Full FIFO: push in the ack cycle of a DATA read is accepted, count stays full.
    opb_xfer(0, 1'b1, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D);
    rd(1);

    // Flush, then underflow on an empty read and clear it.
    wr(2, 32'h4);
    rd(1);
    rd(0);
    rd(1);
    wr(2, 32'h2);
    rd(1);

    // Empty read with a coincident push returns 0 but keeps the word.
    opb_xfer(0, 1'b1, 32'h0, 4'hF, 1'b1, 32'hA5A5A5A5);
    rd(1);
    rd(0);
    wr(2, 32'h2);

    // Flush beats a coincident push.
    push_word(32'h01010101);
    push_word(32'h02020202);
    opb_xfer(2, 1'b0, 32'h4, 4'hF, 1'b1, 32'hDEADBEEF);
    rd(1);

    // Held select on STATUS acks every other cycle.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_status());
      exp_rd_q.push_back(1);
    end
    @(posedge clk); #1;
    bus.OPB_ABus = BASE + 32'd4;
    bus.OPB_RNW = 1'b1;
    bus.OPB_select = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check("hold_ack", 32'(bus.Sl_xferAck), 32'(i % 2));
    end
    bus.OPB_select = 1'b0;

    // Addresses just outside the window never ack.
    @(posedge clk); #1;
    bus.OPB_ABus = BASE + 32'h100;
    bus.OPB_select = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("oow_high_ack", 32'(bus.Sl_xferAck), 32'h0);
    end
    bus.OPB_ABus = BASE - 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("oow_low_ack", 32'(bus.Sl_xferAck), 32'h0);
    end
    bus.OPB_select = 1'b0;

    // Reserved offsets: acked, no effect.
    push_word(32'h77777777);
    wr(0, 32'hFFFFFFFF);
    wr(1, 32'hFFFFFFFF);
    wr(3, 32'hFFFFFFFF);
    opb_xfer(2, 1'b0, 32'h7, 4'h0, 1'b0, 32'h0);
    rd(3);
    rd(2);
    rd(1);

    // Randomized mix of pushes and register traffic.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) push_word($urandom);
      else if (op <= 5) rd(0);
      else if (op == 6) rd(1);
      else if (op == 7) begin
        logic [31:0] d;
        d = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) d[2] = 1'b1;
        opb_xfer(2, 1'b0, d, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
      end else if (op == 8) opb_xfer(0, 1'b1, 32'h0, 4'hF, 1'b1, $urandom);
      else begin
        if ($urandom_range(0, 1) == 1) rd(3);
        else wr($urandom_range(0, 1) == 1 ? 3 : 0, $urandom);
      end
    end
    rd(1);

    // Reset during a DATA read suppresses the ack and discards the FIFO.
    wr(2, 32'h7);
    for (int i = 0; i < 5; i++) push_word($urandom);
    @(posedge clk); #1;
    bus.OPB_ABus = BASE;
    bus.OPB_RNW = 1'b1;
    bus.OPB_select = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.OPB_select = 1'b0;
    model_q.delete();
    m_ovf = 0;
    m_unf = 0;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_ack", 32'(bus.Sl_xferAck), 32'h0);
      @(posedge clk); #1;
    end
    rd(1);

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
